// File: rtl/dff_arb_pkg.sv
// Shared types, default sizes and the round-robin pointer update used by the
// DFF bank arbiter.
package dff_arb_pkg;

  typedef enum logic [0:0] {
    IDLE,
    GRANT
  } state_t;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned DW_DEF   = 8;

  // Served winner moves the pointer just past itself; an abort leaves it alone.
  function automatic int unsigned rr_next(int unsigned ptr, int unsigned w, int unsigned nreq,
                                          logic served);
    if (!served) begin
      return ptr;
    end
    return (w + 1 >= nreq) ? 0 : w + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ...
// modulo NREQ. Produces a one-hot pick, its index and a valid bit.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  int unsigned cand;

  // Walk outward from ptr; the first hit wins and later hits are masked by valid.
  always_comb begin
    pick  = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = (32'(ptr) + off) % NREQ;
      if (!valid && req[cand[IW-1:0]]) begin
        valid              = 1'b1;
        pick[cand[IW-1:0]] = 1'b1;
        idx                = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sharing one DW-bit register among NREQ requesters.
// Each access runs request -> grant -> capture/ack; a requester that drops
// req while granted aborts without writing.
// Optional: define DFF_ARB_PARITY_EN to add q_par, the XOR reduction of q.
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned DW   = DW_DEF,
  localparam int unsigned IW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic               ack,
  output logic [IW-1:0]      owner,
  output logic [DW-1:0]      q,
  output logic               busy
`ifdef DFF_ARB_PARITY_EN
  ,
  output logic               q_par
`endif
);

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     win_q, win_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [DW-1:0]     q_q, q_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic              ack_q, ack_d;

  logic [NREQ-1:0]   pick;
  logic [IW-1:0]     pick_idx;
  logic              pick_valid;
  logic [DW-1:0]     wslice [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign wslice[i] = wdata[i*DW +: DW];
  end

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .pick  (pick),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Next-state: arbitrate in IDLE, capture or abort in GRANT.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = '0;
    q_d     = q_q;
    owner_d = owner_q;
    ack_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick;
          win_d   = pick_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        state_d = IDLE;
        if (req[win_q]) begin
          q_d     = wslice[win_q];
          owner_d = win_q;
          ack_d   = 1'b1;
          ptr_d   = IW'(rr_next(32'(ptr_q), 32'(win_q), NREQ, 1'b1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      q_q     <= '0;
      owner_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      q_q     <= q_d;
      owner_q <= owner_d;
      ack_q   <= ack_d;
    end
  end

`ifdef DFF_ARB_PARITY_EN
  logic q_par_q;

  // Parity tracks q on the same edge it is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_par_q <= 1'b0;
    end else begin
      q_par_q <= ^q_d;
    end
  end

  assign q_par = q_par_q;
`endif

  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign owner = owner_q;
  assign q     = q_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter (NREQ=4, DW=8): a vector table covers
// round-robin, single requester, fairness and abort; hand sequences cover
// asynchronous reset mid-grant and the optional parity output.
module tb_dff_bank_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic        ack;
  logic [1:0]  owner;
  logic [7:0]  q;
  logic        busy;
`ifdef DFF_ARB_PARITY_EN
  logic        q_par;
`endif

  int checks;
  int failures;

  dff_bank_arbiter #(
    .NREQ (4),
    .DW   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .ack   (ack),
    .owner (owner),
    .q     (q),
    .busy  (busy)
`ifdef DFF_ARB_PARITY_EN
    ,
    .q_par (q_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic        ack;
    logic [7:0]  q;
    logic [1:0]  owner;
    logic        busy;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  function automatic vec_t mk(logic [3:0] r, logic [31:0] wd, logic [3:0] g, logic a,
                              logic [7:0] qq, logic [1:0] o, logic b);
    vec_t v;
    v.req = r; v.wdata = wd; v.gnt = g; v.ack = a; v.q = qq; v.owner = o; v.busy = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic a, input logic [7:0] qq,
                         input logic [1:0] o, input logic b);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".ack"}, 32'(ack), 32'(a));
    chk({tag, ".q"}, 32'(q), 32'(qq));
    chk({tag, ".owner"}, 32'(owner), 32'(o));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;

    //             req      wdata         gnt     ack  q      own  busy
    // Round-robin from ptr=0, all requesting, wdata[i] = 0x10+i.
    vecs[0]  = mk(4'b1111, 32'h13121110, 4'b0001, 0, 8'h00, 2'd0, 1);
    vecs[1]  = mk(4'b1111, 32'h13121110, 4'b0000, 1, 8'h10, 2'd0, 0);
    vecs[2]  = mk(4'b1111, 32'h13121110, 4'b0010, 0, 8'h10, 2'd0, 1);
    vecs[3]  = mk(4'b1111, 32'h13121110, 4'b0000, 1, 8'h11, 2'd1, 0);
    vecs[4]  = mk(4'b1111, 32'h13121110, 4'b0100, 0, 8'h11, 2'd1, 1);
    vecs[5]  = mk(4'b1111, 32'h13121110, 4'b0000, 1, 8'h12, 2'd2, 0);
    vecs[6]  = mk(4'b1111, 32'h13121110, 4'b1000, 0, 8'h12, 2'd2, 1);
    vecs[7]  = mk(4'b1111, 32'h13121110, 4'b0000, 1, 8'h13, 2'd3, 0);
    vecs[8]  = mk(4'b1111, 32'h13121110, 4'b0001, 0, 8'h13, 2'd3, 1);
    vecs[9]  = mk(4'b1111, 32'h13121110, 4'b0000, 1, 8'h10, 2'd0, 0);
    vecs[10] = mk(4'b0000, 32'h00000000, 4'b0000, 0, 8'h10, 2'd0, 0);
    // Single requester 2 with 0xA5 (ptr=1).
    vecs[11] = mk(4'b0100, 32'h00A50000, 4'b0100, 0, 8'h10, 2'd0, 1);
    vecs[12] = mk(4'b0100, 32'h00A50000, 4'b0000, 1, 8'hA5, 2'd2, 0);
    vecs[13] = mk(4'b0000, 32'h00000000, 4'b0000, 0, 8'hA5, 2'd2, 0);
    // Serve 0 so ptr=1, then 0 and 3 compete: 3 goes first.
    vecs[14] = mk(4'b0001, 32'h00000055, 4'b0001, 0, 8'hA5, 2'd2, 1);
    vecs[15] = mk(4'b0001, 32'h00000055, 4'b0000, 1, 8'h55, 2'd0, 0);
    vecs[16] = mk(4'b1001, 32'h66000077, 4'b1000, 0, 8'h55, 2'd0, 1);
    vecs[17] = mk(4'b1001, 32'h66000077, 4'b0000, 1, 8'h66, 2'd3, 0);
    vecs[18] = mk(4'b0001, 32'h66000077, 4'b0001, 0, 8'h66, 2'd3, 1);
    vecs[19] = mk(4'b0001, 32'h66000077, 4'b0000, 1, 8'h77, 2'd0, 0);
    vecs[20] = mk(4'b0000, 32'h00000000, 4'b0000, 0, 8'h77, 2'd0, 0);
    // Abort requester 2 with ptr=1; ptr must stay 1 so 1 beats 3 next.
    vecs[21] = mk(4'b0100, 32'h00EE0000, 4'b0100, 0, 8'h77, 2'd0, 1);
    vecs[22] = mk(4'b0000, 32'h00EE0000, 4'b0000, 0, 8'h77, 2'd0, 0);
    vecs[23] = mk(4'b1010, 32'h4400BB00, 4'b0010, 0, 8'h77, 2'd0, 1);
    vecs[24] = mk(4'b1010, 32'h4400BB00, 4'b0000, 1, 8'hBB, 2'd1, 0);
    vecs[25] = mk(4'b0000, 32'h00000000, 4'b0000, 0, 8'hBB, 2'd1, 0);

    rst_n = 1'b0;
    req   = '0;
    wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
`ifdef DFF_ARB_PARITY_EN
    chk("reset.q_par", 32'(q_par), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      req   = vecs[i].req;
      wdata = vecs[i].wdata;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].ack, vecs[i].q, vecs[i].owner,
              vecs[i].busy);
    end

    // Asynchronous reset while requester 1 holds a grant.
    req   = 4'b0010;
    wdata = 32'h0000CC00;
    step();
    chk("rstmid.gnt_before", 32'(gnt), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rstmid", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge clk);
    chk("rstmid.q_held", 32'(q), 32'h00);

    // After release ptr is 0 again: requester 0 wins over a full request set.
    req   = 4'b1111;
    wdata = 32'h00000007;
    rst_n = 1'b1;
    step();
    chk_all("postrst", 4'b0001, 1'b0, 8'h00, 2'd0, 1'b1);
    step();
    chk_all("wr07", 4'b0000, 1'b1, 8'h07, 2'd0, 1'b0);
`ifdef DFF_ARB_PARITY_EN
    chk("wr07.q_par", 32'(q_par), 32'd1);
`endif
    req = 4'b0000;
    step();
    chk("wr07.ack_one_cycle", 32'(ack), 32'd0);
    req   = 4'b0001;
    wdata = 32'h00000003;
    step();
    chk("wr03.gnt", 32'(gnt), 32'h1);
    step();
    chk_all("wr03", 4'b0000, 1'b1, 8'h03, 2'd0, 1'b0);
`ifdef DFF_ARB_PARITY_EN
    chk("wr03.q_par", 32'(q_par), 32'd0);
`endif
    req = 4'b0000;
    step();
    chk("idle.q_hold", 32'(q), 32'h03);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
